result_stream_ctrl: RTL
=======================

# result_stream_ctrl

Ping-pong result buffer at the output of the systolic array, sitting opposite the weight-load path. Accepts one `ARRAY_COL*8`-bit result row per cycle from the array into the write bank. On a bank swap, it drains the filled bank to the DMA as a 64-bit AXI-Stream master with backpressure and `tlast`. Each row is split into two beats, low half first.

## Interface
Parameters:
- `ARRAY_COL`, default `` `ARRAY_COL`` from `params.vh` (16): lanes per row; each lane is 8 bits.
- `DEPTH_LOG2`, default 4: rows per bank, as log2 (16 rows).

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset. Synchronous and active-low; the polarity and synchronicity are fixed.
- `i_res_vec`, input, `ARRAY_COL*8`: result row from the array.
- `i_res_valid`, input, 1: write the row this cycle. There is no backpressure toward the array.
- `i_bank_swap`, input, 1: single-cycle pulse. Closes the write bank and starts draining it.
- `m_axis_tdata`, output, 64: stream data.
- `m_axis_tvalid`, output, 1: stream valid.
- `m_axis_tready`, input, 1: stream ready from the DMA.
- `m_axis_tlast`, output, 1: asserted on the final beat of a bank.
- `o_busy`, output, 1: drain in progress.
- `o_overflow`, output, 1: sticky flag, set when a write is dropped because the bank is full.
- `o_swap_err`, output, 1: one-cycle pulse when a swap is rejected.

## Operation
- **Banks.**
  - `bank_sel` selects the write bank; the drain reads `~bank_sel`.
  - RAM has `2^(DEPTH_LOG2+1)` rows, addressed as `{bank, row}`.
- **Write side.**
  - On `i_res_valid`, write `i_res_vec` to `{bank_sel, wr_cnt}` and increment `wr_cnt`.
  - When `wr_cnt` = `2^DEPTH_LOG2`, the write is dropped and `o_overflow` sets. `wr_cnt` saturates and does not wrap.
- **Swap acceptance.**
  - A swap is accepted only when the drain FSM is IDLE.
  - On acceptance: toggle `bank_sel`, latch `drain_len` = `wr_cnt` (including a write occurring the same cycle), clear `wr_cnt` to 0.
  - A swap while busy is ignored, and `o_swap_err` pulses the next cycle.
- **Drain FSM states.**
  - IDLE: wait for an accepted swap.
    - If `drain_len` = 0, stay in IDLE; no beats are emitted.
    - Otherwise go to FETCH and issue the read of row 0.
  - FETCH: the RAM read is registered (1 cycle). Load `row_reg`, then go to LO.
  - LO: present `row_reg[63:0]`. On handshake go to HI, and issue the read of the next row if one remains.
  - HI: present `row_reg[127:64]`.
    - On handshake, if it is the last row: assert `tlast` on this beat and go to IDLE.
    - Otherwise load `row_reg` from the prefetched RAM output and go to LO. No bubble between rows.
  - For `ARRAY_COL` ≠ 16 the row is split into `ARRAY_COL/8` beats, with the LO/HI sequencing generalised to a beat counter. The default build is 2 beats per row.
- **Stream rules.**
  - Once `m_axis_tvalid` rises it stays high, with stable `tdata` and `tlast`, until `tready`.
  - `tlast` is high only on the final HI beat.
- **Status.** `o_busy` is high in every state except IDLE.
- **Simultaneous events.**
  - Write and accepted swap in the same cycle: the row lands in the old bank, is counted, and is drained.
  - Writes during a drain go to the new write bank unaffected.
- **Reset mid-operation.** The drain aborts with no `tlast` and all state clears. RAM contents are not cleared.

## Timing
- **Reset values.**
  - `m_axis_tdata` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `o_busy` = 0, `o_overflow` = 0, `o_swap_err` = 0.
  - Internally `bank_sel` = 0, `wr_cnt` = 0, FSM = IDLE.
- **Latency.** With an accepted swap sampled at edge T, `o_busy` = 1 after T, and the first `tvalid` (LO beat of row 0) is high after edge T+2.
- **Throughput.** With `tready` held high, N rows take exactly 2N consecutive beats.
- **Drain turnaround.** The cycle after the `tlast` handshake, `o_busy` = 0 and a new swap is accepted.
- **Write timing.** A write is visible to a drain that starts on any later accepted swap; there is no read-during-write hazard because the banks are disjoint.

## Structure
- Shared package / `params.vh` holds `ARRAY_COL`, `AXIS_W` = 64, and the FSM state encodings (IDLE, FETCH, LO, HI) as localparams.
- Sub-module `result_pingpong_ram`: simple dual-port array with a registered read port and a write-enable write port. It is inferred as LUTRAM/BRAM and has no reset on its contents.
- The top level holds the write counter, swap logic, drain FSM, and the output register.

## Test plan
- **Basic drain.** Write 4 rows with row k = {16{8'(k+1)}}, then swap, `tready` = 1. Expect 8 back-to-back beats: 0x0101…01 ×2, 0x0202…02 ×2, and so on, with `tlast` only on beat 8 and first `tvalid` 2 cycles after the swap.
- **Backpressure.** Same data as above with `tready` toggling 1-0-0-1 repeating. Expect `tdata`/`tlast` stable while stalled and no beat lost or duplicated.
- **Full and overflow.** Write 18 rows, then swap. Expect 32 beats, rows 17–18 absent, `o_overflow` = 1 and still sticky after the drain.
- **Swap while busy.** Swap during the drain of 3 rows. Expect `o_swap_err` pulse, no `bank_sel` change, and the drain completes with 6 beats; a second swap after `tlast` is accepted.
- **Empty and edge cases.** Swap with 0 rows: expect no `tvalid` and `o_busy` low after 1 cycle. Write plus swap in the same cycle with 1 row prior: expect 2 rows drained.
- **Reset mid-drain.** Assert `rst_n` = 0 mid-drain. Expect all outputs 0 the next edge, then a new 1-row fill and swap drains 2 beats correctly.

Source files
------------

// File: rtl/result_stream_ctrl_pkg.sv
// Shared constants and drain FSM encoding for the result stream controller.
package result_stream_ctrl_pkg;

    localparam int DEF_ARRAY_COL = 16;
    localparam int AXIS_W        = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LO    = 2'd2,
        ST_HI    = 2'd3
    } drain_state_e;

endpackage

// File: rtl/result_pingpong_ram.sv
// Two-bank result storage: one write port, one registered read port, no content reset.
module result_pingpong_ram #(
    parameter int WIDTH  = 128,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/result_stream_ctrl.sv
// Ping-pong result buffer: fills one bank from the array while the other
// bank is drained as a 64-bit AXI-Stream, low beat of each row first.
module result_stream_ctrl
    import result_stream_ctrl_pkg::*;
#(
    parameter int ARRAY_COL  = DEF_ARRAY_COL,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ARRAY_COL*8-1:0] i_res_vec,
    input  logic                   i_res_valid,
    input  logic                   i_bank_swap,
    output logic [AXIS_W-1:0]      m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   o_busy,
    output logic                   o_overflow,
    output logic                   o_swap_err
);

    localparam int ROW_W  = ARRAY_COL * 8;
    localparam int NBEATS = ROW_W / AXIS_W;
    localparam int BEAT_W = (NBEATS > 2) ? $clog2(NBEATS) : 1;
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0]  ROWS      = CNT_W'(2**DEPTH_LOG2);
    localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);
    localparam logic [BEAT_W-1:0] PRE_LAST  = BEAT_W'(NBEATS - 2);

    drain_state_e            state_q;
    logic                    bank_sel_q;
    logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]        drain_len_q, cur_row_q;
    logic [CNT_W-1:0]        swap_len_d;
    logic [BEAT_W-1:0]       beat_q;
    logic                    fetch_pend_q;
    logic [ROW_W-1:0]        row_q;
    logic [AXIS_W-1:0]       tdata_q;
    logic                    tvalid_q, tlast_q;
    logic                    overflow_q, swap_err_q;

    logic                    wr_full, wr_fire, swap_ok, handshake, last_row;
    logic                    ram_re;
    logic [DEPTH_LOG2:0]     ram_waddr, ram_raddr;
    logic [DEPTH_LOG2-1:0]   next_row_idx;
    logic [ROW_W-1:0]        ram_rdata;

    assign wr_full      = (wr_cnt_q == ROWS);
    assign wr_fire      = i_res_valid && !wr_full;
    assign swap_ok      = i_bank_swap && (state_q == ST_IDLE);
    assign handshake    = tvalid_q && m_axis_tready;
    assign last_row     = ((cur_row_q + ONE_CNT) == drain_len_q);
    assign next_row_idx = DEPTH_LOG2'(cur_row_q + ONE_CNT);
    assign ram_waddr    = {bank_sel_q, wr_cnt_q[DEPTH_LOG2-1:0]};

    // A write landing in the swap cycle still belongs to the closing bank.
    always_comb begin
        swap_len_d = wr_cnt_q + (wr_fire ? ONE_CNT : '0);
        wr_cnt_d   = wr_cnt_q;
        if (swap_ok) begin
            wr_cnt_d = '0;
        end else if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + ONE_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_sel_q <= 1'b0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            if (swap_ok) begin
                bank_sel_q <= ~bank_sel_q;
            end
            if (i_res_valid && wr_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Next row is prefetched as the row's second-to-last beat is accepted.
    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = {~bank_sel_q, next_row_idx};
        if (state_q == ST_FETCH && !fetch_pend_q) begin
            ram_re    = 1'b1;
            ram_raddr = {~bank_sel_q, {DEPTH_LOG2{1'b0}}};
        end else if (state_q == ST_LO && handshake && beat_q == PRE_LAST && !last_row) begin
            ram_re = 1'b1;
        end
    end

    result_pingpong_ram #(
        .WIDTH  (ROW_W),
        .ADDR_W (DEPTH_LOG2 + 1)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_fire),
        .waddr_i (ram_waddr),
        .wdata_i (i_res_vec),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            drain_len_q  <= '0;
            cur_row_q    <= '0;
            beat_q       <= '0;
            fetch_pend_q <= 1'b0;
            row_q        <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            swap_err_q   <= 1'b0;
        end else begin
            swap_err_q <= i_bank_swap && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (swap_ok) begin
                        drain_len_q  <= swap_len_d;
                        cur_row_q    <= '0;
                        beat_q       <= '0;
                        fetch_pend_q <= 1'b0;
                        if (swap_len_d != '0) begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (!fetch_pend_q) begin
                        fetch_pend_q <= 1'b1;
                    end else begin
                        fetch_pend_q <= 1'b0;
                        row_q        <= ram_rdata;
                        tdata_q      <= ram_rdata[AXIS_W-1:0];
                        tvalid_q     <= 1'b1;
                        tlast_q      <= 1'b0;
                        state_q      <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (handshake) begin
                        beat_q  <= beat_q + BEAT_W'(1);
                        tdata_q <= row_q[(int'(beat_q) + 1) * AXIS_W +: AXIS_W];
                        if (beat_q == PRE_LAST) begin
                            tlast_q <= last_row;
                            state_q <= ST_HI;
                        end
                    end
                end
                ST_HI: begin
                    if (handshake) begin
                        beat_q  <= '0;
                        tlast_q <= 1'b0;
                        if (tlast_q) begin
                            tvalid_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            cur_row_q <= cur_row_q + ONE_CNT;
                            row_q     <= ram_rdata;
                            tdata_q   <= ram_rdata[AXIS_W-1:0];
                            state_q   <= ST_LO;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_overflow    = overflow_q;
    assign o_swap_err    = swap_err_q;

endmodule
